// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, redirect/stall/flush handling,
// and combinational field decode of the latched word. Optional counters under FETCH_PERF_CNT_EN.
module if_id_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0040_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr_id,
    output logic [DATA_WIDTH-1:0] pc_plus4_id,
    output logic                  valid_id,
    output logic [5:0]            opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [5:0]            funct,
    output logic [15:0]           imm
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           bubble_count
`endif
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   pc_next;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic                    redirect;
    logic                    latch_fetch;
    logic                    latch_bubble;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: BOOT lasts exactly one cycle, only reset re-enters it
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // Output/control logic. During BOOT the ID stage holds a reset bubble, so any
    // redirect/stall/flush it might raise is meaningless and the first fetch always proceeds.
    always_comb begin
        imem_addr    = (state == BOOT) ? PC_RESET : pc;
        pc_plus4     = imem_addr + 32'd4;
        pc_next      = pc;
        redirect     = 1'b0;
        latch_fetch  = 1'b0;
        latch_bubble = 1'b0;
        if (state == BOOT) begin
            pc_next     = pc_plus4;
            latch_fetch = 1'b1;
        end else begin
            if (jump) begin
                pc_next  = {pc_plus4_id[31:28], jump_index, 2'b00};
                redirect = 1'b1;
            end else if (branch_taken) begin
                pc_next  = branch_target & ~32'h3;
                redirect = 1'b1;
            end else if (!stall) begin
                pc_next = pc_plus4;
            end

            // The word fetched alongside a redirect is wrong-path and becomes a bubble
            if (flush || redirect) begin
                latch_bubble = 1'b1;
            end else if (!stall) begin
                latch_fetch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_id    <= '0;
            pc_plus4_id <= '0;
            valid_id    <= 1'b0;
        end else if (latch_bubble) begin
            instr_id    <= '0;
            pc_plus4_id <= '0;
            valid_id    <= 1'b0;
        end else if (latch_fetch) begin
            instr_id    <= imem_rdata;
            pc_plus4_id <= pc_plus4;
            valid_id    <= 1'b1;
        end
    end

    assign opcode = instr_id[31:26];
    assign rs     = instr_id[25:21];
    assign rt     = instr_id[20:16];
    assign rd     = instr_id[15:11];
    assign shamt  = instr_id[10:6];
    assign funct  = instr_id[5:0];
    assign imm    = instr_id[15:0];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (latch_fetch) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (latch_bubble) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage with a combinational instruction-memory model.
module tb_if_id_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int vectors;
    int miscompares;

    if_id_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_id(instr_id), .pc_plus4_id(pc_plus4_id), .valid_id(valid_id),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        if (a == 32'h0040_0034) return 32'h012A_40A0;
        return a ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_rdata = imem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;
        tick();
        tick();
        vectors++; if (valid_id !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", valid_id); end
        vectors++; if (instr_id !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=0", instr_id); end
        vectors++; if (pc_plus4_id !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 got=%h exp=0", pc_plus4_id); end
        vectors++; if (imem_addr !== 32'h0040_0000) begin miscompares++; $display("FAIL reset_addr got=%h exp=00400000", imem_addr); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        vectors++; if (valid_id !== 1'b1) begin miscompares++; $display("FAIL boot_valid got=%0b exp=1", valid_id); end
        vectors++; if (opcode !== 6'h08) begin miscompares++; $display("FAIL boot_opcode got=%h exp=08", opcode); end
        vectors++; if (rt !== 5'd8) begin miscompares++; $display("FAIL boot_rt got=%0d exp=8", rt); end
        vectors++; if (imm !== 16'd5) begin miscompares++; $display("FAIL boot_imm got=%0d exp=5", imm); end
        vectors++; if (pc_plus4_id !== 32'h0040_0004) begin miscompares++; $display("FAIL boot_pc4 got=%h exp=00400004", pc_plus4_id); end
        vectors++; if (imem_addr !== 32'h0040_0004) begin miscompares++; $display("FAIL boot_addr got=%h exp=00400004", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        vectors++; if (fetch_count !== 32'd1) begin miscompares++; $display("FAIL boot_fcnt got=%0d exp=1", fetch_count); end
        vectors++; if (bubble_count !== 32'd0) begin miscompares++; $display("FAIL boot_bcnt got=%0d exp=0", bubble_count); end
`endif
        tick();
        vectors++; if (instr_id !== 32'h5A1A_0004) begin miscompares++; $display("FAIL run_instr got=%h exp=5a1a0004", instr_id); end
        vectors++; if (pc_plus4_id !== 32'h0040_0008) begin miscompares++; $display("FAIL run_pc4 got=%h exp=00400008", pc_plus4_id); end
        vectors++; if (imem_addr !== 32'h0040_0008) begin miscompares++; $display("FAIL run_addr got=%h exp=00400008", imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (imem_addr !== 32'h0040_0008) begin miscompares++; $display("FAIL stall_addr[%0d] got=%h exp=00400008", i, imem_addr); end
            vectors++; if (instr_id !== 32'h5A1A_0004) begin miscompares++; $display("FAIL stall_instr[%0d] got=%h exp=5a1a0004", i, instr_id); end
            vectors++; if (pc_plus4_id !== 32'h0040_0008) begin miscompares++; $display("FAIL stall_pc4[%0d] got=%h exp=00400008", i, pc_plus4_id); end
            vectors++; if (valid_id !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got=%0b exp=1", i, valid_id); end
        end
        stall = 1'b0;
        tick();
        vectors++; if (instr_id !== 32'h5A1A_0008) begin miscompares++; $display("FAIL unstall_instr got=%h exp=5a1a0008", instr_id); end
        tick();
        vectors++; if (pc_plus4_id !== 32'h0040_0010) begin miscompares++; $display("FAIL unstall_pc4 got=%h exp=00400010", pc_plus4_id); end
        vectors++; if (imem_addr !== 32'h0040_0010) begin miscompares++; $display("FAIL unstall_addr got=%h exp=00400010", imem_addr); end
    endtask

    task automatic test_jump();
        jump = 1'b1; jump_index = 26'h010_0005;
        tick();
        jump = 1'b0;
        vectors++; if (imem_addr !== 32'h0040_0014) begin miscompares++; $display("FAIL jump_addr got=%h exp=00400014", imem_addr); end
        vectors++; if (valid_id !== 1'b0) begin miscompares++; $display("FAIL jump_bubble_valid got=%0b exp=0", valid_id); end
        vectors++; if (instr_id !== 32'h0) begin miscompares++; $display("FAIL jump_bubble_instr got=%h exp=0", instr_id); end
        tick();
        vectors++; if (valid_id !== 1'b1) begin miscompares++; $display("FAIL jump_tgt_valid got=%0b exp=1", valid_id); end
        vectors++; if (instr_id !== 32'h5A1A_0014) begin miscompares++; $display("FAIL jump_tgt_instr got=%h exp=5a1a0014", instr_id); end
        vectors++; if (pc_plus4_id !== 32'h0040_0018) begin miscompares++; $display("FAIL jump_tgt_pc4 got=%h exp=00400018", pc_plus4_id); end
    endtask

    task automatic test_branch_stall();
        branch_taken = 1'b1; branch_target = 32'h0040_0033; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        vectors++; if (imem_addr !== 32'h0040_0030) begin miscompares++; $display("FAIL br_addr got=%h exp=00400030", imem_addr); end
        vectors++; if (valid_id !== 1'b0) begin miscompares++; $display("FAIL br_bubble_valid got=%0b exp=0", valid_id); end
        vectors++; if (instr_id !== 32'h0) begin miscompares++; $display("FAIL br_bubble_instr got=%h exp=0", instr_id); end
        tick();
        vectors++; if (instr_id !== 32'h5A1A_0030) begin miscompares++; $display("FAIL br_tgt_instr got=%h exp=5a1a0030", instr_id); end
        vectors++; if (pc_plus4_id !== 32'h0040_0034) begin miscompares++; $display("FAIL br_tgt_pc4 got=%h exp=00400034", pc_plus4_id); end
    endtask

    task automatic test_flush_stall();
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        vectors++; if (instr_id !== 32'h0) begin miscompares++; $display("FAIL flush_instr got=%h exp=0", instr_id); end
        vectors++; if (valid_id !== 1'b0) begin miscompares++; $display("FAIL flush_valid got=%0b exp=0", valid_id); end
        vectors++; if (pc_plus4_id !== 32'h0) begin miscompares++; $display("FAIL flush_pc4 got=%h exp=0", pc_plus4_id); end
        vectors++; if (imem_addr !== 32'h0040_0034) begin miscompares++; $display("FAIL flush_addr got=%h exp=00400034", imem_addr); end
    endtask

    task automatic test_decode();
        tick();
        vectors++; if (opcode !== 6'h00) begin miscompares++; $display("FAIL dec_opcode got=%h exp=00", opcode); end
        vectors++; if (rs !== 5'd9) begin miscompares++; $display("FAIL dec_rs got=%0d exp=9", rs); end
        vectors++; if (rt !== 5'd10) begin miscompares++; $display("FAIL dec_rt got=%0d exp=10", rt); end
        vectors++; if (rd !== 5'd8) begin miscompares++; $display("FAIL dec_rd got=%0d exp=8", rd); end
        vectors++; if (shamt !== 5'd2) begin miscompares++; $display("FAIL dec_shamt got=%0d exp=2", shamt); end
        vectors++; if (funct !== 6'h20) begin miscompares++; $display("FAIL dec_funct got=%h exp=20", funct); end
        vectors++; if (imm !== 16'h40A0) begin miscompares++; $display("FAIL dec_imm got=%h exp=40a0", imm); end
        vectors++; if (pc_plus4_id !== 32'h0040_0038) begin miscompares++; $display("FAIL dec_pc4 got=%h exp=00400038", pc_plus4_id); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_tgt got=%h exp=fffffffc", imem_addr); end
        tick();
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
        vectors++; if (instr_id !== 32'hA5A5_FFFC) begin miscompares++; $display("FAIL wrap_instr got=%h exp=a5a5fffc", instr_id); end
        vectors++; if (pc_plus4_id !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4_id); end
        vectors++; if (valid_id !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got=%0b exp=1", valid_id); end
    endtask

    task automatic test_reset_mid();
        branch_taken = 1'b1; branch_target = 32'h0040_0020;
        tick();
        branch_taken = 1'b0;
        vectors++; if (imem_addr !== 32'h0040_0020) begin miscompares++; $display("FAIL mid_pre_addr got=%h exp=00400020", imem_addr); end
        tick();
        reset = 1'b1; jump = 1'b1; jump_index = 26'h3FF_FFFF;
        tick();
        reset = 1'b0; jump = 1'b0;
        vectors++; if (imem_addr !== 32'h0040_0000) begin miscompares++; $display("FAIL mid_addr got=%h exp=00400000", imem_addr); end
        vectors++; if (valid_id !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%0b exp=0", valid_id); end
        vectors++; if (instr_id !== 32'h0) begin miscompares++; $display("FAIL mid_instr got=%h exp=0", instr_id); end
`ifdef FETCH_PERF_CNT_EN
        vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("FAIL mid_fcnt got=%0d exp=0", fetch_count); end
        vectors++; if (bubble_count !== 32'd0) begin miscompares++; $display("FAIL mid_bcnt got=%0d exp=0", bubble_count); end
`endif
        tick();
        vectors++; if (opcode !== 6'h08) begin miscompares++; $display("FAIL mid_boot_opcode got=%h exp=08", opcode); end
        vectors++; if (imem_addr !== 32'h0040_0004) begin miscompares++; $display("FAIL mid_boot_addr got=%h exp=00400004", imem_addr); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_fetch();
        test_stall();
        test_jump();
        test_branch_stall();
        test_flush_stall();
        test_decode();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS core.
- Holds the PC, drives the instruction-memory address, and latches the fetched word with its PC+4.
- Exposes decoded fields, including the 6-bit opcode consumed directly by the Control unit.
- Handles stall, flush and branch/jump redirect.

Parameters:
- PC_RESET, 32'h0040_0000, PC value loaded on reset (MARS text base).
- DATA_WIDTH, 32, instruction/PC width; only 32 is supported.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID contents
- flush  input  1  squash IF/ID contents (insert bubble)
- branch_taken  input  1  ID stage resolved a taken BEQ/BNE
- branch_target  input  32  branch destination byte address
- jump  input  1  ID stage decoded J/JAL
- jump_index  input  26  instr[25:0] of the jump in ID
- imem_addr  output  32  current PC to instruction memory
- imem_rdata  input  32  instruction word; combinational read of imem_addr in the same cycle
- instr_id  output  32  latched instruction
- pc_plus4_id  output  32  PC+4 of the latched instruction
- valid_id  output  1  latched instruction is real (not a bubble)
- opcode  output  6  instr_id[31:26], to Control
- rs, rt, rd  output  5 each  instr_id[25:21], [20:16], [15:11]
- shamt  output  5  instr_id[10:6]
- funct  output  6  instr_id[5:0]
- imm  output  16  instr_id[15:0]

Behaviour:
- Reset (sync, high):
  - PC <= PC_RESET; instr_id <= 0; pc_plus4_id <= 0; valid_id <= 0; FSM <= BOOT.
  - Reset overrides all other inputs in the same cycle.
- FSM states:
  - BOOT: first cycle after reset. imem_addr = PC_RESET. Next edge latches the fetched word with valid=1, PC <= PC+4, state -> RUN.
  - RUN: normal operation.
  - Only reset returns the FSM to BOOT.
- Next-PC priority (highest first):
  1. reset
  2. jump: PC <= {pc_plus4_id[31:28], jump_index, 2'b00}
  3. branch_taken: PC <= {branch_target[31:2], 2'b00}
  4. stall: PC holds
  5. default: PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0)
- A redirect (jump or branch_taken) overrides stall.
- IF/ID register priority:
  1. reset
  2. flush: instr_id <= 0 (sll $0 NOP, opcode 0), valid_id <= 0, pc_plus4_id <= 0
  3. redirect: same bubble as flush, squashing the wrong-path word fetched this cycle
  4. stall: hold all three registers
  5. default: instr_id <= imem_rdata, pc_plus4_id <= PC+4, valid_id <= 1
- Simultaneous stall and flush: flush wins (bubble), PC holds unless a redirect is also present.
- Latency:
  - Fetch-to-ID is 1 cycle.
  - Taken redirect costs exactly 1 bubble; the target word appears in ID 2 edges after redirect assertion.
- Decoded field outputs are pure combinational slices of instr_id; no extra latency.
- PC[1:0] is always 0; branch_target[1:0] is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN
- Defined:
  - Adds outputs fetch_count[31:0] and bubble_count[31:0], both reset to 0.
  - fetch_count increments on every edge that latches a valid instruction.
  - bubble_count increments on every edge that latches a bubble (flush or redirect), not on stall or BOOT.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run, imem returning 32'h2008_0005 at 0x00400000 -> after 1st edge valid_id=1, opcode=6'h08, rt=8, imm=5, pc_plus4_id=0x00400004; imem_addr=0x00400004.
- stall held 3 cycles from PC=0x00400008 -> imem_addr stays 0x00400008; instr_id and pc_plus4_id unchanged; valid_id unchanged.
- jump=1, jump_index=26'h0100005, pc_plus4_id=0x00400010 -> next PC=0x00400014; valid_id=0 for 1 cycle; then instr from 0x00400014 with valid_id=1.
- branch_taken=1, branch_target=0x00400033, stall=1, same cycle -> PC=0x00400030 (low bits masked, stall overridden); IF/ID bubble.
- flush=1 with stall=1 -> instr_id=0, valid_id=0, PC held.
- Reset asserted mid-run at PC=0x00400020 -> next edge PC=0x00400000, valid_id=0, BOOT; with FETCH_PERF_CNT_EN defined, both counters=0.
